bnn_cmd_parser: RTL and testbench
=================================

# bnn_cmd_parser

Byte-level command parser between the UART receiver and the BNN core. It consumes the received byte stream, frames and checksums host commands, and streams image payload into the BNN input buffer. It also pulses the inference start and returns a one-byte response to the UART transmit path. All protocol state lives here, so the UART blocks stay protocol-agnostic.

## Interface
- IMG_BYTES, 16: capacity of the image buffer in bytes; legal payload length is 1..IMG_BYTES.
- TIMEOUT_CYCLES, 100000: idle clocks allowed between bytes of one frame before it is abandoned.
- SYNC_BYTE, 8'hA5: frame start marker.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_byte  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- infer_busy  in  1  BNN core is running an inference.
- img_wr_en  out  1  image buffer write strobe.
- img_wr_addr  out  $clog2(IMG_BYTES)  write address.
- img_wr_data  out  8  write data.
- img_valid  out  1  a complete, checksum-correct image is loaded.
- start_infer  out  1  one-cycle inference start pulse.
- resp_byte  out  8  response to the host.
- resp_valid  out  1  resp_byte valid; held until accepted.
- resp_ready  in  1  transmit path accepts resp_byte when resp_valid & resp_ready.
- err_timeout  out  1  one-cycle pulse when a frame is abandoned on timeout.
- rx_overrun  out  1  one-cycle pulse when a byte is dropped in RESP.

## Operation
- Frame: SYNC, CMD, [LEN, payload x LEN,] CHK.
  - CHK = XOR of CMD, LEN (if present) and all payload bytes.
  - SYNC is excluded from CHK.
- Commands:
  - 8'h01 LOAD: has LEN and payload.
  - 8'h02 START: CMD, CHK only.
  - 8'h03 STATUS: CMD, CHK only.
- States: IDLE -> CMD -> (LEN -> PAYLOAD ->) CHK -> RESP -> IDLE.
- IDLE: discard every byte except SYNC_BYTE; SYNC moves to CMD.
- CMD: known command goes to LEN (LOAD) or CHK (START/STATUS). Unknown command goes straight to RESP with NACK.
- LEN: 0 or >IMG_BYTES goes to RESP with NACK. Otherwise latch LEN, clear img_valid, zero the address counter, go to PAYLOAD.
- PAYLOAD: each byte is written at img_wr_addr, then the address increments. After the LEN-th byte, go to CHK.
- CHK: a mismatch gives NACK (8'h15). A match gives:
  - LOAD: set img_valid, ACK (8'h06).
  - START: if img_valid & !infer_busy, pulse start_infer and ACK; otherwise NACK.
  - STATUS: resp_byte = {6'b0, infer_busy, img_valid}.
- RESP: hold resp_byte/resp_valid until the handshake, then go to IDLE. Bytes arriving in RESP are dropped and pulse rx_overrun.
- Timeout: in CMD, LEN, PAYLOAD and CHK, an idle counter counts cycles without rx_valid and clears on each rx_valid.
  - When it reaches TIMEOUT_CYCLES: pulse err_timeout, go to IDLE, send no response.
  - img_valid stays 0 if the timeout hits a LOAD after LEN.
- A partially written buffer is never flagged valid. Payload writes go through immediately; validity is gated only by CHK.

## Timing
- Reset values: state IDLE; all outputs 0, including img_valid, resp_byte, address and counters.
- img_wr_en/addr/data are registered and assert the cycle after the payload rx_valid.
- resp_valid asserts the cycle after the CHK byte's rx_valid, or after the CMD/LEN byte on an immediate NACK.
- start_infer pulses in the same cycle resp_valid first asserts with ACK.
- resp_valid & resp_ready in cycle N puts state in IDLE at N+1; a SYNC at N+1 is accepted.
- rx_valid and the resp handshake in the same cycle: the byte counts as arriving in RESP and is dropped.
- Asynchronous reset mid-frame aborts immediately: img_valid=0, no response.
- Address counter width is $clog2(IMG_BYTES). It never wraps because LEN ≤ IMG_BYTES.

## Structure
- The shared package bnn_pkg holds:
  - the state enum (IDLE, CMD, LEN, PAYLOAD, CHK, RESP);
  - command constants CMD_LOAD/CMD_START/CMD_STATUS;
  - RESP_ACK/RESP_NACK.
- One natural sub-module, bnn_timeout_counter: an idle counter with clear and enable inputs and a single-cycle expire output.

## Test plan
- LOAD: A5 01 02 FF 0F F3 -> writes FF@0 and 0F@1, resp 06, img_valid=1.
- LOAD with bad CHK (A5 01 02 FF 0F 00) -> two writes occur, resp 15, img_valid=0.
- After a good LOAD, send START A5 02 02 with infer_busy=0 -> start_infer one pulse, resp 06. Repeat with infer_busy=1 -> resp 15, no pulse.
- STATUS A5 03 03 with img_valid=1, infer_busy=1 -> resp 03.
- Length and command errors:
  - LEN=0 (A5 01 00) -> resp 15.
  - LEN=17 -> resp 15.
  - unknown CMD 7E -> resp 15, and trailing bytes are ignored until the next A5.
- LOAD A5 01 04 AA, then silence for TIMEOUT_CYCLES -> err_timeout pulse, no response, img_valid=0. Next, hold resp_ready=0 while an extra byte arrives in RESP -> rx_overrun pulse.

Source files
------------

// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bnn_pkg
// Purpose  : Shared types and protocol constants for the BNN command parser.
// Revision : 1.0 - initial release
// ============================================================================
package bnn_pkg;

  // Parser states; the encoding is internal to the parser.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  // Host command codes
  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_START  = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;

  // Response codes
  localparam logic [7:0] RESP_ACK  = 8'h06;
  localparam logic [7:0] RESP_NACK = 8'h15;

  // Commands without LEN/payload go straight from CMD to CHK.
  function automatic logic is_short_cmd(input logic [7:0] cmd);
    return (cmd == CMD_START) || (cmd == CMD_STATUS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : bnn_cmd_parser_if
// Purpose  : Byte stream, image-buffer write port, response handshake and
//            status pulses of the BNN command parser. The master side is the
//            surrounding system (UART RX/TX, BNN core); the slave side is the
//            parser itself.
// Revision : 1.0 - initial release
// ============================================================================
interface bnn_cmd_parser_if #(
  parameter int IMG_BYTES = 16
);
  localparam int AW = $clog2(IMG_BYTES);

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          infer_busy;
  logic          img_wr_en;
  logic [AW-1:0] img_wr_addr;
  logic [7:0]    img_wr_data;
  logic          img_valid;
  logic          start_infer;
  logic [7:0]    resp_byte;
  logic          resp_valid;
  logic          resp_ready;
  logic          err_timeout;
  logic          rx_overrun;

  modport master (
    output rx_byte, rx_valid, infer_busy, resp_ready,
    input  img_wr_en, img_wr_addr, img_wr_data, img_valid, start_infer,
           resp_byte, resp_valid, err_timeout, rx_overrun
  );

  modport slave (
    input  rx_byte, rx_valid, infer_busy, resp_ready,
    output img_wr_en, img_wr_addr, img_wr_data, img_valid, start_infer,
           resp_byte, resp_valid, err_timeout, rx_overrun
  );

endinterface
`default_nettype wire

// File: rtl/bnn_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : bnn_timeout_counter
// Purpose  : Idle-cycle counter. Counts enabled cycles without a clear and
//            raises a single-cycle expire once TIMEOUT_CYCLES idle cycles
//            have elapsed; the count restarts after expiry.
// Revision : 1.0 - initial release
// ============================================================================
module bnn_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Expire on the TIMEOUT_CYCLES-th consecutive idle cycle.
  assign o_expire = i_enable & ~i_clear & (r_count == c_last);

  // Idle count: restart on activity, when disabled, or after expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || !i_enable || o_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bnn_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : bnn_cmd_parser
// Purpose  : Frames and checksums host commands from the UART byte stream,
//            streams LOAD payload into the image buffer, pulses inference
//            start and returns a one-byte response.
// Revision : 1.0 - initial release
// ============================================================================
module bnn_cmd_parser
  import bnn_pkg::*;
#(
  parameter int         IMG_BYTES      = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  bnn_cmd_parser_if.slave bus
);

  localparam int         AW        = $clog2(IMG_BYTES);
  localparam logic [7:0] c_max_len = 8'(IMG_BYTES);

  state_t        r_state;
  logic [7:0]    r_cmd;
  logic [7:0]    r_len;
  logic [7:0]    r_chk;
  logic [AW-1:0] r_addr;
  logic          r_img_wr_en;
  logic [AW-1:0] r_img_wr_addr;
  logic [7:0]    r_img_wr_data;
  logic          r_img_valid;
  logic          r_start_infer;
  logic [7:0]    r_resp_byte;
  logic          r_resp_valid;
  logic          r_err_timeout;
  logic          r_rx_overrun;

  logic          w_timer_en;
  logic          w_expire;
  logic          w_last_payload;
  logic          w_len_bad;

  // The idle timer only runs while a frame is in flight.
  assign w_timer_en = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                      (r_state == ST_PAYLOAD) || (r_state == ST_CHK);

  // The byte being accepted now is the LEN-th payload byte.
  assign w_last_payload = ({{(8-AW){1'b0}}, r_addr} == (r_len - 8'd1));

  assign w_len_bad = (bus.rx_byte == 8'd0) || (bus.rx_byte > c_max_len);

  bnn_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (bus.rx_valid),
    .i_enable (w_timer_en),
    .o_expire (w_expire)
  );

  // Frame parser FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_len         <= '0;
      r_chk         <= '0;
      r_addr        <= '0;
      r_img_wr_en   <= 1'b0;
      r_img_wr_addr <= '0;
      r_img_wr_data <= '0;
      r_img_valid   <= 1'b0;
      r_start_infer <= 1'b0;
      r_resp_byte   <= '0;
      r_resp_valid  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_rx_overrun  <= 1'b0;
    end else begin
      r_img_wr_en   <= 1'b0;
      r_start_infer <= 1'b0;
      r_err_timeout <= 1'b0;
      r_rx_overrun  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.rx_valid && (bus.rx_byte == SYNC_BYTE)) begin
            r_state <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (bus.rx_valid) begin
            r_cmd <= bus.rx_byte;
            r_chk <= bus.rx_byte;
            if (bus.rx_byte == CMD_LOAD) begin
              r_state <= ST_LEN;
            end else if (is_short_cmd(bus.rx_byte)) begin
              r_state <= ST_CHK;
            end else begin
              r_resp_byte  <= RESP_NACK;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end
          end
        end

        ST_LEN: begin
          if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (bus.rx_valid) begin
            if (w_len_bad) begin
              r_resp_byte  <= RESP_NACK;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              // The old image is invalid as soon as an overwrite begins.
              r_len       <= bus.rx_byte;
              r_chk       <= r_chk ^ bus.rx_byte;
              r_img_valid <= 1'b0;
              r_addr      <= '0;
              r_state     <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (bus.rx_valid) begin
            r_img_wr_en   <= 1'b1;
            r_img_wr_addr <= r_addr;
            r_img_wr_data <= bus.rx_byte;
            r_chk         <= r_chk ^ bus.rx_byte;
            r_addr        <= r_addr + 1'b1;
            if (w_last_payload) begin
              r_state <= ST_CHK;
            end
          end
        end

        ST_CHK: begin
          if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (bus.rx_valid) begin
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
            if (bus.rx_byte != r_chk) begin
              r_resp_byte <= RESP_NACK;
            end else begin
              case (r_cmd)
                CMD_LOAD: begin
                  r_img_valid <= 1'b1;
                  r_resp_byte <= RESP_ACK;
                end
                CMD_START: begin
                  if (r_img_valid && !bus.infer_busy) begin
                    r_start_infer <= 1'b1;
                    r_resp_byte   <= RESP_ACK;
                  end else begin
                    r_resp_byte <= RESP_NACK;
                  end
                end
                CMD_STATUS: begin
                  r_resp_byte <= {6'b0, bus.infer_busy, r_img_valid};
                end
                default: begin
                  r_resp_byte <= RESP_NACK;
                end
              endcase
            end
          end
        end

        ST_RESP: begin
          // Bytes arriving here are lost, even in the handshake cycle.
          if (bus.rx_valid) begin
            r_rx_overrun <= 1'b1;
          end
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.img_wr_en   = r_img_wr_en;
  assign bus.img_wr_addr = r_img_wr_addr;
  assign bus.img_wr_data = r_img_wr_data;
  assign bus.img_valid   = r_img_valid;
  assign bus.start_infer = r_start_infer;
  assign bus.resp_byte   = r_resp_byte;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.err_timeout = r_err_timeout;
  assign bus.rx_overrun  = r_rx_overrun;

endmodule
`default_nettype wire

// File: tb/tb_bnn_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_cmd_parser
// Purpose  : Self-checking bench for bnn_cmd_parser: directed frames from the
//            protocol description plus randomized frames scored against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bnn_cmd_parser;
  import bnn_pkg::*;

  localparam int IMG = 16;
  localparam int TO  = 64;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_cyc = 0;

  bnn_cmd_parser_if #(.IMG_BYTES(IMG)) bus ();

  bnn_cmd_parser #(
    .IMG_BYTES      (IMG),
    .TIMEOUT_CYCLES (TO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, sampled on the falling edge.
  logic [15:0] wr_q[$];
  logic [7:0]  resp_q[$];
  int start_cnt = 0, misalign = 0, to_cnt = 0, to_cyc = 0, ov_cnt = 0;

  always @(negedge clk) begin
    if (bus.img_wr_en) wr_q.push_back({4'b0, bus.img_wr_addr, bus.img_wr_data});
    if (bus.resp_valid && bus.resp_ready) resp_q.push_back(bus.resp_byte);
    if (bus.start_infer) begin
      start_cnt++;
      if (!(bus.resp_valid && bus.resp_byte == RESP_ACK)) misalign++;
    end
    if (bus.err_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (bus.rx_overrun) ov_cnt++;
  end

  // Reference model state and per-frame expectations.
  bit          m_img_valid = 1'b0;
  logic [15:0] exp_wr[$];
  int          exp_resp;
  int          exp_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-frame model: decides response, writes and start from the frame bytes.
  task automatic model_frame(input bq_t fr, input bit busy);
    int len;
    logic [7:0] x;
    exp_wr.delete();
    exp_resp  = -1;
    exp_start = 0;
    if (fr[1] == 8'h01) begin
      len = int'(fr[2]);
      if (len == 0 || len > IMG) begin
        exp_resp = RESP_NACK;
      end else begin
        x = fr[1] ^ fr[2];
        for (int i = 0; i < len; i++) begin
          exp_wr.push_back({8'(i), fr[3+i]});
          x = x ^ fr[3+i];
        end
        m_img_valid = (x == fr[3+len]);
        exp_resp = m_img_valid ? RESP_ACK : RESP_NACK;
      end
    end else if (fr[1] == 8'h02 || fr[1] == 8'h03) begin
      if (fr[2] != fr[1]) exp_resp = RESP_NACK;
      else if (fr[1] == 8'h03) exp_resp = {busy, m_img_valid};
      else if (m_img_valid && !busy) begin
        exp_resp  = RESP_ACK;
        exp_start = 1;
      end else exp_resp = RESP_NACK;
    end else begin
      exp_resp = RESP_NACK;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive bytes starting now (just after a rising edge), optional gaps.
  task automatic send_bytes(input bq_t fr, input int maxgap);
    foreach (fr[i]) begin
      bus.rx_byte  = fr[i];
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      last_cyc     = cyc;
      bus.rx_valid = 1'b0;
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_frame(input string tag, input bq_t fr, input bit busy);
    int rb, wb, sb;
    model_frame(fr, busy);
    rb = resp_q.size(); wb = wr_q.size(); sb = start_cnt;
    bus.infer_busy = busy;
    send_bytes(fr, 2);
    idle(6);
    check({tag, " resp_count"}, resp_q.size() - rb, (exp_resp >= 0) ? 1 : 0);
    if (exp_resp >= 0 && resp_q.size() > rb) check({tag, " resp"}, resp_q[rb], exp_resp);
    check({tag, " wr_count"}, wr_q.size() - wb, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && wb + i < wr_q.size(); i++)
      check({tag, " wr"}, wr_q[wb+i], exp_wr[i]);
    check({tag, " start"}, start_cnt - sb, exp_start);
    check({tag, " img_valid"}, bus.img_valid, m_img_valid);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t fr, junk;
    int rb, wb, tb0, ob, kind, len, nj;
    bit busy;
    logic [7:0] b, x;

    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0;
    bus.infer_busy = 1'b0; bus.resp_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    check("rst img_valid", bus.img_valid, 0);
    check("rst resp_valid", bus.resp_valid, 0);
    check("rst resp_byte", bus.resp_byte, 0);
    check("rst img_wr_en", bus.img_wr_en, 0);
    check("rst img_wr_addr", bus.img_wr_addr, 0);
    check("rst start_infer", bus.start_infer, 0);
    check("rst err_timeout", bus.err_timeout, 0);
    check("rst rx_overrun", bus.rx_overrun, 0);

    // Directed frames
    fr = '{8'hA5, 8'h01, 8'h02, 8'hFF, 8'h0F, 8'hF3}; run_frame("load_ok", fr, 0);
    fr = '{8'hA5, 8'h01, 8'h02, 8'hFF, 8'h0F, 8'h00}; run_frame("load_badchk", fr, 0);
    fr = '{8'hA5, 8'h01, 8'h02, 8'hFF, 8'h0F, 8'hF3}; run_frame("load_ok2", fr, 0);
    fr = '{8'hA5, 8'h02, 8'h02};                      run_frame("start_idle", fr, 0);
    fr = '{8'hA5, 8'h02, 8'h02};                      run_frame("start_busy", fr, 1);
    fr = '{8'hA5, 8'h03, 8'h03};                      run_frame("status", fr, 1);
    fr = '{8'hA5, 8'h01, 8'h00};                      run_frame("len0", fr, 0);
    fr = '{8'hA5, 8'h01, 8'h11};                      run_frame("len17", fr, 0);
    fr = '{8'hA5, 8'h7E};                             run_frame("badcmd", fr, 0);
    rb = resp_q.size();
    fr = '{8'h7E, 8'h00, 8'h03};
    send_bytes(fr, 0); idle(4);
    check("trailing ignored", resp_q.size() - rb, 0);

    // Timeout during LOAD payload
    fr = '{8'hA5, 8'h01, 8'h04, 8'hAA};
    rb = resp_q.size(); wb = wr_q.size(); tb0 = to_cnt;
    send_bytes(fr, 0);
    for (int i = 0; i < TO + 20 && to_cnt == tb0; i++) begin @(posedge clk); #1; end
    idle(2);
    m_img_valid = 1'b0;
    check("timeout pulses", to_cnt - tb0, 1);
    check("timeout delay", to_cyc - last_cyc, TO);
    check("timeout no resp", resp_q.size() - rb, 0);
    check("timeout writes", wr_q.size() - wb, 1);
    check("timeout img_valid", bus.img_valid, 0);

    // Overrun while the response is held, then SYNC right after handshake
    bus.resp_ready = 1'b0; bus.infer_busy = 1'b1;
    fr = '{8'hA5, 8'h03, 8'h03};
    model_frame(fr, 1);
    rb = resp_q.size(); ob = ov_cnt;
    send_bytes(fr, 0);
    check("resp latency", bus.resp_valid, 1);
    check("held resp_byte", bus.resp_byte, exp_resp);
    junk = '{8'h55};
    send_bytes(junk, 0); idle(2);
    check("overrun pulse", ov_cnt - ob, 1);
    check("resp still held", bus.resp_valid, 1);
    check("no early handshake", resp_q.size() - rb, 0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    send_bytes(fr, 0); idle(6);
    check("sync after handshake", resp_q.size() - rb, 2);
    if (resp_q.size() - rb == 2) check("second status", resp_q[rb+1], exp_resp);

    // Randomized frames against the model
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 5);
      busy = 1'($urandom_range(0, 1));
      nj   = $urandom_range(0, 2);
      junk = {};
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        junk.push_back(b);
      end
      send_bytes(junk, 1);
      fr = {8'hA5};
      case (kind)
        0, 1: begin
          len = $urandom_range(1, IMG);
          fr.push_back(8'h01); fr.push_back(8'(len));
          x = 8'h01 ^ 8'(len);
          for (int j = 0; j < len; j++) begin
            b = 8'($urandom_range(0, 255));
            fr.push_back(b); x = x ^ b;
          end
          if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
          fr.push_back(x);
        end
        2: begin
          fr.push_back(8'h01);
          fr.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(IMG + 1, 255)));
        end
        3, 4: begin
          b = (kind == 3) ? 8'h02 : 8'h03;
          fr.push_back(b);
          fr.push_back(($urandom_range(0, 3) == 0) ? (b ^ 8'($urandom_range(1, 255))) : b);
        end
        default: begin
          b = 8'($urandom_range(4, 255));
          fr.push_back(b);
        end
      endcase
      run_frame($sformatf("rand%0d", k), fr, busy);
    end

    // Asynchronous reset in the middle of a LOAD
    fr = '{8'hA5, 8'h01, 8'h01, 8'h5A, 8'h5A}; run_frame("pre_reset_load", fr, 0);
    rb = resp_q.size();
    fr = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22};
    send_bytes(fr, 0);
    #2 rst = 1'b1;
    #1;
    check("async rst img_valid", bus.img_valid, 0);
    check("async rst resp_valid", bus.resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_img_valid = 1'b0;
    idle(4);
    check("async rst no resp", resp_q.size() - rb, 0);
    fr = '{8'hA5, 8'h03, 8'h03}; run_frame("post_reset_status", fr, 0);

    check("start aligned with ack", misalign, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
